// File: rtl/sc_pkg.sv
// rtl/sc_pkg.sv - shared constants and types for the stochastic-computing FIR epoch control
package sc_pkg;
  localparam int SC_N     = 12;
  localparam int SC_ORDER = 18;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} sc_epoch_state_t;
  typedef logic [SC_N:0] sc_count_t;
endpackage

// File: rtl/sc_epoch_ctrl_if.sv
// rtl/sc_epoch_ctrl_if.sv - sample, VDC, datapath and result signals of sc_epoch_ctrl
// SC_EPOCH_TRUNC_EN adds the epoch_log2 input.
interface sc_epoch_ctrl_if #(parameter int N = 12);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_sample;
  logic         vdc_clear;
  logic [N-1:0] vdc_re;
  logic         sc_bit;
  logic         sc_bit_valid;
  logic         dp_bit;
  logic         out_valid;
  logic         out_ready;
  logic [N:0]   out_result;
  logic         busy;
`ifdef SC_EPOCH_TRUNC_EN
  logic [$clog2(N+1)-1:0] epoch_log2;
`endif

  modport master (
`ifdef SC_EPOCH_TRUNC_EN
    output epoch_log2,
`endif
    output in_valid, in_sample, vdc_re, dp_bit, out_ready,
    input  in_ready, vdc_clear, sc_bit, sc_bit_valid, out_valid, out_result, busy
  );

  modport slave (
`ifdef SC_EPOCH_TRUNC_EN
    input  epoch_log2,
`endif
    input  in_valid, in_sample, vdc_re, dp_bit, out_ready,
    output in_ready, vdc_clear, sc_bit, sc_bit_valid, out_valid, out_result, busy
  );
endinterface

// File: rtl/sc_valid_delay.sv
// rtl/sc_valid_delay.sv - DP_LAT-stage valid delay line with an "empty" flag
module sc_valid_delay #(
  parameter int DP_LAT = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic valid_in,
  output logic valid_out,
  output logic empty
);
  generate
    if (DP_LAT == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clock ^ reset;
      assign valid_out = valid_in;
      assign empty     = 1'b1;
    end else begin : g_shift
      logic [DP_LAT-1:0] stage_q, stage_d, head_mask;

      always_comb begin
        stage_d    = stage_q << 1;
        stage_d[0] = valid_in;
      end

      always_ff @(posedge clock) begin
        if (!reset) stage_q <= '0;
        else        stage_q <= stage_d;
      end

      // empty: nothing queued behind the output stage, so the current output is the last one
      assign head_mask = {DP_LAT{1'b1}} >> 1;
      assign valid_out = stage_q[DP_LAT-1];
      assign empty     = !valid_in && !(|(stage_q & head_mask));
    end
  endgenerate
endmodule

// File: rtl/sc_epoch_ctrl.sv
// rtl/sc_epoch_ctrl.sv - epoch sequencer: sample in, 2^L-cycle bitstream out, ones count back
// SC_EPOCH_TRUNC_EN enables the shortened epoch of 2^epoch_log2 cycles.
module sc_epoch_ctrl
  import sc_pkg::*;
#(
  parameter int N      = SC_N,
  parameter int DP_LAT = 0
) (
  input  logic           clock,
  input  logic           reset,
  sc_epoch_ctrl_if.slave bus
);
  localparam logic [N:0]   ONE      = {{N{1'b0}}, 1'b1};
  localparam logic [N:0]   ONES_MAX = {1'b1, {N{1'b0}}};
  localparam logic [N-1:0] RUN_ONE  = {{(N-1){1'b0}}, 1'b1};

  sc_epoch_state_t state_q, state_d;
  logic [N-1:0] sample_q, sample_d;
  logic [N-1:0] run_cnt_q, run_cnt_d;
  logic [N:0]   ones_q, ones_d;
  logic [N:0]   result_q, result_d;
  logic sc_bit_q, sc_bit_d, sc_valid_q, sc_valid_d;
  logic out_valid_q, out_valid_d, vdc_clear_q, vdc_clear_d;
  logic in_ready_q, in_ready_d, busy_q, busy_d;
  logic accept, run_last, dp_valid, dl_empty;
  logic [N:0] run_term, result_full;

`ifdef SC_EPOCH_TRUNC_EN
  localparam int LW = $clog2(N + 1);
  localparam logic [2*N:0] SAT = {{N{1'b0}}, 1'b1, {N{1'b0}}};
  logic [LW-1:0] l_q, l_d;
  logic [2*N:0]  scaled;

  always_comb begin
    l_d = l_q;
    if (accept)
      l_d = (bus.epoch_log2 == '0 || int'(bus.epoch_log2) > N) ? LW'(N) : bus.epoch_log2;
  end

  always_ff @(posedge clock) begin
    if (!reset) l_q <= LW'(N);
    else        l_q <= l_d;
  end

  assign run_term    = (ONE << l_q) - ONE;
  assign scaled      = {{N{1'b0}}, ones_d} << (LW'(N) - l_q);
  assign result_full = (scaled > SAT) ? SAT[N:0] : scaled[N:0];
`else
  assign run_term    = {1'b0, {N{1'b1}}};
  assign result_full = ones_d;
`endif

  assign run_last = ({1'b0, run_cnt_q} == run_term);

  sc_valid_delay #(.DP_LAT(DP_LAT)) u_vdly (
    .clock     (clock),
    .reset     (reset),
    .valid_in  (sc_valid_q),
    .valid_out (dp_valid),
    .empty     (dl_empty)
  );

  always_comb begin
    state_d   = state_q;
    sample_d  = sample_q;
    run_cnt_d = run_cnt_q;
    result_d  = result_q;
    accept    = 1'b0;
    unique case (state_q)
      IDLE: if (bus.in_valid) begin
        accept    = 1'b1;
        sample_d  = bus.in_sample;
        run_cnt_d = '0;
        state_d   = RUN;
      end
      RUN: begin
        run_cnt_d = run_cnt_q + RUN_ONE;
        if (run_last) state_d = DRAIN;
      end
      DRAIN: if (dl_empty) state_d = DONE;
      DONE:  if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ones_d = ones_q;
    if (accept) ones_d = '0;
    else if (dp_valid && bus.dp_bit && ones_q != ONES_MAX) ones_d = ones_q + ONE;

    // the last delayed bit is counted on the same edge that enters DONE, so use ones_d
    if (state_q == DRAIN && dl_empty) result_d = result_full;

    sc_valid_d  = (state_q == RUN);
    sc_bit_d    = (state_q == RUN) && (bus.vdc_re < sample_q);
    out_valid_d = (state_d == DONE);
    vdc_clear_d = (state_d != RUN);
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      sample_q    <= '0;
      run_cnt_q   <= '0;
      ones_q      <= '0;
      result_q    <= '0;
      sc_bit_q    <= 1'b0;
      sc_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      vdc_clear_q <= 1'b1;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sample_q    <= sample_d;
      run_cnt_q   <= run_cnt_d;
      ones_q      <= ones_d;
      result_q    <= result_d;
      sc_bit_q    <= sc_bit_d;
      sc_valid_q  <= sc_valid_d;
      out_valid_q <= out_valid_d;
      vdc_clear_q <= vdc_clear_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.vdc_clear    = vdc_clear_q;
  assign bus.sc_bit       = sc_bit_q;
  assign bus.sc_bit_valid = sc_valid_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_result   = result_q;
  assign bus.busy         = busy_q;
endmodule

// File: tb/tb_sc_epoch_ctrl.sv
// tb/tb_sc_epoch_ctrl.sv - two controllers (DP_LAT 0 and 3) run in lockstep against VDC and datapath models
// SC_EPOCH_TRUNC_EN adds truncated-epoch vectors.
module tb_sc_epoch_ctrl;
  import sc_pkg::*;

  localparam int N    = SC_N;
  localparam int LAT1 = 3;

  typedef struct {
    logic [N-1:0] sample;
    int           lg;
    int           len;
    int           hold;
    bit           inject;
    sc_count_t    exp_res;
    int           exp_ones;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic inject = 1'b0;
  logic [N-1:0] in_sample = '0;
`ifdef SC_EPOCH_TRUNC_EN
  logic [$clog2(N+1)-1:0] epoch_log2 = '0;
`endif

  int checks = 0;
  int errors = 0;
  sc_count_t q0[$];
  sc_count_t q1[$];
  vec_t vecs[$];

  always #5 clock = ~clock;

  sc_epoch_ctrl_if #(.N(N)) ifc0 ();
  sc_epoch_ctrl_if #(.N(N)) ifc1 ();

  sc_epoch_ctrl #(.N(N), .DP_LAT(0))    u_dut0 (.clock(clock), .reset(reset), .bus(ifc0));
  sc_epoch_ctrl #(.N(N), .DP_LAT(LAT1)) u_dut1 (.clock(clock), .reset(reset), .bus(ifc1));

  function automatic logic [N-1:0] rev(input logic [N-1:0] v);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = v[N-1-i];
    return r;
  endfunction

  // VDC models: counters with synchronous clear, bit-reversed output
  logic [N-1:0] vcnt0, vcnt1;
  always_ff @(posedge clock) begin
    vcnt0 <= ifc0.vdc_clear ? '0 : vcnt0 + 1'b1;
    vcnt1 <= ifc1.vdc_clear ? '0 : vcnt1 + 1'b1;
  end

  logic [LAT1-1:0] dly_v, dly_b;
  always_ff @(posedge clock) begin
    dly_v <= {dly_v[LAT1-2:0], ifc1.sc_bit_valid};
    dly_b <= {dly_b[LAT1-2:0], ifc1.sc_bit};
  end

  assign ifc0.in_valid  = in_valid;
  assign ifc1.in_valid  = in_valid;
  assign ifc0.in_sample = in_sample;
  assign ifc1.in_sample = in_sample;
  assign ifc0.out_ready = out_ready;
  assign ifc1.out_ready = out_ready;
  assign ifc0.vdc_re    = rev(vcnt0);
  assign ifc1.vdc_re    = rev(vcnt1);
  assign ifc0.dp_bit    = ifc0.sc_bit_valid ? ifc0.sc_bit : inject;
  assign ifc1.dp_bit    = dly_v[LAT1-1] ? dly_b[LAT1-1] : inject;
`ifdef SC_EPOCH_TRUNC_EN
  assign ifc0.epoch_log2 = epoch_log2;
  assign ifc1.epoch_log2 = epoch_log2;
`endif

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready0"},  ifc0.in_ready, 1);
    chk({tag, "_in_ready1"},  ifc1.in_ready, 1);
    chk({tag, "_busy0"},      ifc0.busy, 0);
    chk({tag, "_busy1"},      ifc1.busy, 0);
    chk({tag, "_out_valid0"}, ifc0.out_valid, 0);
    chk({tag, "_out_valid1"}, ifc1.out_valid, 0);
    chk({tag, "_vdc_clear0"}, ifc0.vdc_clear, 1);
    chk({tag, "_vdc_clear1"}, ifc1.vdc_clear, 1);
    chk({tag, "_sc_valid0"},  ifc0.sc_bit_valid, 0);
    chk({tag, "_sc_valid1"},  ifc1.sc_bit_valid, 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc, lat0, lat1, ones0, ones1;
    bit rdy_bad;
    sc_count_t e0, e1;
    string t;
    t = $sformatf("v%0d", idx);
    chk({t, "_start_ready0"}, ifc0.in_ready, 1);
    chk({t, "_start_ready1"}, ifc1.in_ready, 1);
    in_sample = v.sample;
    inject    = v.inject;
`ifdef SC_EPOCH_TRUNC_EN
    epoch_log2 = v.lg[$clog2(N+1)-1:0];
`endif
    in_valid = 1'b1;
    q0.push_back(v.exp_res);
    q1.push_back(v.exp_res);
    @(posedge clock); #1;
    in_valid = 1'b0;
    cyc = 0; lat0 = -1; lat1 = -1; ones0 = 0; ones1 = 0; rdy_bad = 1'b0;
    e0 = '0; e1 = '0;
    while ((lat0 < 0 || lat1 < 0) && cyc < v.len + 20) begin
      @(posedge clock); #1;
      cyc++;
      ones0 += int'(ifc0.sc_bit);
      ones1 += int'(ifc1.sc_bit);
      if (ifc0.in_ready || ifc1.in_ready) rdy_bad = 1'b1;
      if (lat0 < 0 && ifc0.out_valid) begin
        lat0 = cyc;
        chk({t, "_sb0_size"}, q0.size(), 1);
        if (q0.size() > 0) e0 = q0.pop_front();
        chk({t, "_result0"}, ifc0.out_result, e0);
      end
      if (lat1 < 0 && ifc1.out_valid) begin
        lat1 = cyc;
        chk({t, "_sb1_size"}, q1.size(), 1);
        if (q1.size() > 0) e1 = q1.pop_front();
        chk({t, "_result1"}, ifc1.out_result, e1);
      end
    end
    chk({t, "_latency0"}, lat0, v.len + 1);
    chk({t, "_latency1"}, lat1, v.len + LAT1 + 1);
    chk({t, "_sc_ones0"}, ones0, v.exp_ones);
    chk({t, "_sc_ones1"}, ones1, v.exp_ones);
    chk({t, "_in_ready_low"}, rdy_bad, 0);
    for (int h = 0; h < v.hold; h++) begin
      in_valid = h[0];
      @(posedge clock); #1;
      chk({t, "_hold_valid0"},  ifc0.out_valid, 1);
      chk({t, "_hold_valid1"},  ifc1.out_valid, 1);
      chk({t, "_hold_result0"}, ifc0.out_result, e0);
      chk({t, "_hold_result1"}, ifc1.out_result, e1);
      chk({t, "_hold_ready"},   ifc0.in_ready | ifc1.in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk_idle({t, "_release"});
  endtask

  initial begin
    vecs.push_back('{sample: 12'd1000, lg: 0, len: 4096, hold: 0,  inject: 1'b0, exp_res: 13'd1000, exp_ones: 1000});
    vecs.push_back('{sample: 12'd0,    lg: 0, len: 4096, hold: 2,  inject: 1'b0, exp_res: 13'd0,    exp_ones: 0});
    vecs.push_back('{sample: 12'd4095, lg: 0, len: 4096, hold: 0,  inject: 1'b0, exp_res: 13'd4095, exp_ones: 4095});
    vecs.push_back('{sample: 12'd2048, lg: 0, len: 4096, hold: 10, inject: 1'b1, exp_res: 13'd2048, exp_ones: 2048});
    vecs.push_back('{sample: 12'd1,    lg: 0, len: 4096, hold: 1,  inject: 1'b1, exp_res: 13'd1,    exp_ones: 1});
`ifdef SC_EPOCH_TRUNC_EN
    vecs.push_back('{sample: 12'd1000, lg: 4, len: 16,   hold: 0,  inject: 1'b0, exp_res: 13'd1024, exp_ones: 4});
    vecs.push_back('{sample: 12'd1000, lg: 0, len: 4096, hold: 0,  inject: 1'b0, exp_res: 13'd1000, exp_ones: 1000});
`endif

    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk_idle("reset");
    chk("reset_result0", ifc0.out_result, 0);
    chk("reset_result1", ifc1.out_result, 0);
    chk("reset_sc_bit0", ifc0.sc_bit, 0);
    reset = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    // abort an epoch mid-run; no result may appear for it
    in_sample = 12'd1234;
    inject    = 1'b0;
    in_valid  = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (500) @(posedge clock);
    #1;
    chk("abort_busy_before", ifc0.busy & ifc1.busy, 1);
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    chk_idle("abort");

    for (int i = 4; i < vecs.size(); i++) run_vec(vecs[i], i);

    chk("sb0_drained", q0.size(), 0);
    chk("sb1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
